// File: rtl/scpad_tail_q.sv
// Scratchpad response tail queue: splits one response stream into per-destination FIFOs.
// Each destination's FIFO drains independently, and out-of-range sources are dropped and flagged.
module scpad_tail_q #(
    parameter int                        SCPAD_ID_WIDTH = 4,
    parameter logic [SCPAD_ID_WIDTH-1:0] IDX            = '0,
    parameter int                        NUM_SRC        = 2,
    parameter int                        DEPTH          = 4,
    parameter int                        DATA_W         = 256,
    localparam int                       SRC_W          = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1,
    localparam int                       CNT_W          = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_write,
    input  logic [SRC_W-1:0]            in_src,
    input  logic [DATA_W-1:0]           in_rdata,
    output logic                        in_ready,
    output logic [NUM_SRC-1:0]          out_valid,
    output logic [NUM_SRC-1:0]          out_write,
    output logic [NUM_SRC*DATA_W-1:0]   out_rdata,
    input  logic [NUM_SRC-1:0]          out_ready,
    output logic [NUM_SRC*CNT_W-1:0]    occ,
    output logic                        err_bad_src,
    output logic [SCPAD_ID_WIDTH-1:0]   err_idx
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] rdata;
    } entry_t;

    entry_t            mem_q    [NUM_SRC][DEPTH];
    entry_t            mem_d    [NUM_SRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]  occ_q    [NUM_SRC];
    logic [CNT_W-1:0]  occ_d    [NUM_SRC];
    logic              err_bad_src_q;
    logic              err_bad_src_d;

    logic               src_bad;
    logic               push;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] push_s;
    logic [NUM_SRC-1:0] pop_s;
    entry_t             in_entry;

    assign err_idx = IDX;

    // in_ready looks only at occupancy, never at out_ready, so a full FIFO stays closed even while it pops.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        src_bad  = int'(in_src) >= NUM_SRC;
        in_ready = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            full[s] = (occ_q[s] == CNT_W'(DEPTH));
        end
        if (!rst) begin
            in_ready = src_bad ? 1'b1 : !full[in_src];
        end
        push     = in_valid && in_ready && !src_bad;
        in_entry = '{write: in_write, rdata: in_write ? '0 : in_rdata};
    end

    always_comb begin
        mem_d         = mem_q;
        err_bad_src_d = err_bad_src_q | (in_valid & in_ready & src_bad);
        for (int s = 0; s < NUM_SRC; s++) begin
            push_s[s]   = push && (in_src == SRC_W'(s));
            pop_s[s]    = (occ_q[s] != '0) && out_ready[s];
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push_s[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(pop_s[s]);
            occ_d[s]    = occ_q[s] + CNT_W'(push_s[s]) - CNT_W'(pop_s[s]);
            if (push_s[s]) begin
                mem_d[s][wr_ptr_q[s]] = in_entry;
            end
        end
    end

    // Head outputs are forced to zero when empty, so stale storage never leaks out.
    always_comb begin
        out_valid = '0;
        out_write = '0;
        out_rdata = '0;
        occ       = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            out_valid[s] = (occ_q[s] != '0);
            if (out_valid[s]) begin
                out_write[s]                  = mem_q[s][rd_ptr_q[s]].write;
                out_rdata[s*DATA_W +: DATA_W] = mem_q[s][rd_ptr_q[s]].rdata;
            end
            occ[s*CNT_W +: CNT_W] = occ_q[s];
        end
    end

    assign err_bad_src = err_bad_src_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                occ_q[s]    <= '0;
            end
            err_bad_src_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            err_bad_src_q <= err_bad_src_d;
        end
    end

    // NOTE: storage is not reset; entries are only visible through occ, which is reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_scpad_tail_q.sv
// Self-checking bench for scpad_tail_q: directed scenarios followed by random traffic.
// Every cycle is compared against a queue-based reference model.
module tb_scpad_tail_q;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 64;
    localparam int SRC_W   = 2;
    localparam int CNT_W   = 3;
    localparam logic [3:0] IDX = 4'h5;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_write;
    logic [SRC_W-1:0]          in_src;
    logic [DATA_W-1:0]         in_rdata;
    logic                      in_ready;
    logic [NUM_SRC-1:0]        out_valid;
    logic [NUM_SRC-1:0]        out_write;
    logic [NUM_SRC*DATA_W-1:0] out_rdata;
    logic [NUM_SRC-1:0]        out_ready;
    logic [NUM_SRC*CNT_W-1:0]  occ;
    logic                      err_bad_src;
    logic [3:0]                err_idx;

    scpad_tail_q #(
        .SCPAD_ID_WIDTH(4),
        .IDX           (IDX),
        .NUM_SRC       (NUM_SRC),
        .DEPTH         (DEPTH),
        .DATA_W        (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_write   (in_write),
        .in_src     (in_src),
        .in_rdata   (in_rdata),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_write  (out_write),
        .out_rdata  (out_rdata),
        .out_ready  (out_ready),
        .occ        (occ),
        .err_bad_src(err_bad_src),
        .err_idx    (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [63:0] d;
    } ent_t;

    ent_t mq [NUM_SRC][$];
    bit   err_m;
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        for (int s = 0; s < NUM_SRC; s++) begin
            e = (mq[s].size() != 0) ? mq[s][0] : '0;
            check($sformatf("out_valid[%0d]", s), 64'(out_valid[s]), 64'(mq[s].size() != 0));
            check($sformatf("out_write[%0d]", s), 64'(out_write[s]), 64'(e.w));
            check($sformatf("out_rdata[%0d]", s), out_rdata[s*DATA_W +: DATA_W], e.d);
            check($sformatf("occ[%0d]", s), 64'(occ[s*CNT_W +: CNT_W]), 64'(mq[s].size()));
        end
        check("err_bad_src", 64'(err_bad_src), 64'(err_m));
        check("err_idx", 64'(err_idx), 64'(IDX));
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] src,
                         input logic [63:0] d, input logic [2:0] rdy, input logic r);
        in_valid  = v;
        in_write  = w;
        in_src    = src;
        in_rdata  = d;
        out_ready = rdy;
        rst       = r;
    endtask

    // One clock: predict in_ready, let the edge happen, advance the model, compare everything.
    task automatic step();
        logic       exp_rdy;
        logic [2:0] pop;
        #1;
        if (rst)                  exp_rdy = 1'b0;
        else if (in_src >= 3)     exp_rdy = 1'b1;
        else                      exp_rdy = (mq[in_src].size() < DEPTH);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int s = 0; s < NUM_SRC; s++) pop[s] = out_ready[s] && (mq[s].size() != 0);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int s = 0; s < NUM_SRC; s++) mq[s].delete();
            err_m = 1'b0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) if (pop[s]) void'(mq[s].pop_front());
            if (in_valid && exp_rdy) begin
                if (in_src >= 3) err_m = 1'b1;
                else mq[in_src].push_back('{w: in_write, d: in_write ? 64'd0 : in_rdata});
            end
        end
        check_outputs();
    endtask

    localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        err_m   = 1'b0;

        drive(0, 0, 0, 0, 3'b000, 1); step(); step();

        drive(1, 0, 0, A5, 3'b000, 0); step();
        drive(0, 0, 0, 0, 3'b001, 0);  step();
        step();

        drive(1, 1, 1, FF, 3'b000, 0); step();
        drive(0, 0, 0, 0, 3'b010, 0);  step();

        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 0, 64'(i), 3'b000, 0); step();
        end
        drive(0, 0, 0, 0, 3'b001, 0);
        for (int i = 0; i < 5; i++) step();

        drive(1, 0, 0, 64'h11, 3'b000, 0); step();
        drive(1, 1, 0, 64'h22, 3'b000, 0); step();
        drive(1, 0, 1, 64'h33, 3'b000, 0); step();
        drive(1, 0, 0, 64'h44, 3'b011, 0); step();
        drive(0, 0, 0, 0, 3'b111, 0);
        for (int i = 0; i < 3; i++) step();

        drive(1, 0, 2, 64'h55, 3'b000, 0); step();
        drive(1, 0, 3, 64'h66, 3'b000, 0); step();
        drive(0, 0, 0, 0, 3'b000, 0);      step();
        drive(1, 0, 3, 64'h77, 3'b000, 1); step();
        drive(0, 0, 0, 0, 3'b000, 0);      step();

        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 64'(100 + i), 3'b000, 0); step();
        end
        drive(1, 0, 0, 64'hDEAD, 3'b000, 1); step();
        drive(0, 0, 0, 0, 3'b000, 0);        step();

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 3'($urandom), ($urandom_range(0, 63) == 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scpad_tail_q.md
SCPAD_TAIL_Q -- requirements
Module: scpad_tail_q

Interface
REQ-001 SHALL have parameter IDX, default 0, SCPAD_ID_WIDTH bits: scratchpad instance index, carried unchanged to err_idx.
REQ-002 SHALL have parameter NUM_SRC, default 2, range 2..8: number of response destinations; index 0 = FE, 1 = BE, others generic.
REQ-003 SHALL have parameter DEPTH, default 4, power of two, 2..16: entries per destination FIFO.
REQ-004 SHALL have parameter DATA_W, default 256: response read-data width.
REQ-005 SHALL derive SRC_W = max(1, clog2(NUM_SRC)) and CNT_W = clog2(DEPTH)+1.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  response from stomach is offered.
REQ-009 in_write  in  1  1 = write acknowledge, 0 = read response.
REQ-010 in_src  in  SRC_W  destination index.
REQ-011 in_rdata  in  DATA_W  read data; ignored when in_write=1.
REQ-012 in_ready  out  1  response accepted this cycle when in_valid & in_ready.
REQ-013 out_valid  out  NUM_SRC  per-destination head entry valid.
REQ-014 out_write  out  NUM_SRC  per-destination head entry write flag.
REQ-015 out_rdata  out  NUM_SRC x DATA_W  per-destination head entry data.
REQ-016 out_ready  in  NUM_SRC  per-destination consumer accepts head.
REQ-017 occ  out  NUM_SRC x CNT_W  per-destination occupancy, 0..DEPTH.
REQ-018 err_bad_src  out  1  sticky: response received with in_src >= NUM_SRC.
REQ-019 err_idx  out  SCPAD_ID_WIDTH  constant IDX, for error attribution.

Function
REQ-020 SHALL keep one independent FIFO per destination, DEPTH entries of {write, rdata}.
REQ-021 in_ready SHALL be combinational: 1 when in_src >= NUM_SRC, else !full[in_src]; it SHALL NOT depend on out_ready (no same-cycle full pass-through).
REQ-022 On accept with valid in_src, SHALL write {in_write, in_write ? 0 : in_rdata} at wr_ptr[in_src], then increment that pointer.
REQ-023 Write acknowledges SHALL store rdata as all-zero; out_rdata for write entries SHALL be 0.
REQ-024 Latency SHALL be exactly 1 cycle: entry accepted at edge N appears on out_valid after edge N; no combinational bypass.
REQ-025 out_valid[s] = (occ[s] != 0); out_write[s]/out_rdata[s] = head entry of FIFO s; all 0 when FIFO s empty.
REQ-026 Pop of FIFO s SHALL occur when out_valid[s] & out_ready[s]; rd_ptr[s] increments.
REQ-027 Simultaneous push and pop on same s SHALL leave occ[s] unchanged and preserve FIFO order; on a full FIFO, push is refused (in_ready=0) even if pop occurs.
REQ-028 Pushes and pops on different destinations SHALL proceed in the same cycle independently.
REQ-029 Pointers SHALL wrap modulo DEPTH; full = (occ == DEPTH), empty = (occ == 0).
REQ-030 Response with in_src >= NUM_SRC SHALL be accepted and discarded, set err_bad_src, and modify no FIFO.
REQ-031 out_ready on an empty FIFO SHALL have no effect; in_valid=0 SHALL cause no push regardless of other inputs.
REQ-032 Per-destination FIFO order SHALL equal acceptance order; no reordering across read/write types.

Reset
REQ-033 While rst=1 at a clock edge: all pointers and occ SHALL become 0, err_bad_src 0; out_valid, out_write, out_rdata SHALL be 0 after that edge.
REQ-034 Reset mid-operation SHALL discard all queued entries; input accepted in the reset cycle SHALL be dropped.
REQ-035 in_ready SHALL be 0 while rst=1.
REQ-036 err_idx SHALL equal IDX at all times, including reset.

Verification
REQ-037 Read to FE: rst, then in_valid=1, in_write=0, in_src=0, in_rdata=0xA5..A5 for one cycle -> next cycle out_valid=2'b01, out_rdata[0]=0xA5..A5, occ[0]=1; out_ready[0]=1 -> out_valid=0, occ[0]=0.
REQ-038 Write ack to BE: in_write=1, in_src=1, in_rdata=0xFF..FF -> out_valid[1]=1, out_write[1]=1, out_rdata[1]=0.
REQ-039 Backpressure: DEPTH=4, out_ready=0, push 5 reads to src 0 with data 1..5 -> first 4 accepted, in_ready=0 on 5th, occ[0]=4; release out_ready -> data 1,2,3,4 in order.
REQ-040 Concurrency: FIFO 0 holding 2, same cycle push src 0 and pop src 0 plus pop src 1 -> occ[0] stays 2, occ[1] decrements, order kept.
REQ-041 Bad source: NUM_SRC=3, in_src=3 -> in_ready=1, err_bad_src=1 next cycle and stays 1, all occ unchanged; rst clears it.
REQ-042 Mid-reset: occ[0]=3, assert rst one cycle while pushing -> occ all 0, out_valid=0, pushed entry absent.
